// File: rtl/axi_pkg.sv
// axi_pkg: AXI response codes, burst/size encodings and slave state shared by master and slave models
package axi_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_B      = 3'd0;
    localparam logic [2:0] SIZE_H      = 3'd1;
    localparam logic [2:0] SIZE_W      = 3'd2;
    typedef enum logic [2:0] {IDLE, RD_DLY, RD_RESP, WR_COLLECT, WR_DLY, WR_RESP} slave_state_t;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11) for injecting pseudo-random delays
module lfsr16 (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] seed,
    input  logic        enable,
    output logic [15:0] state
);
    always_ff @(posedge clock)
        if (reset) state <= seed;
        else if (enable) state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-outstanding, single-beat AXI4 SRAM slave with programmable plus random response delay
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LAT_MIN     = 0,
    parameter int          LFSR_EN     = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,
    input  logic [3:0]  s_awid,
    input  logic [7:0]  s_awlen,
    input  logic [2:0]  s_awsize,
    input  logic [1:0]  s_awburst,
    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wlast,
    output logic        s_bvalid,
    input  logic        s_bready,
    output logic [1:0]  s_bresp,
    output logic [3:0]  s_bid,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    input  logic [3:0]  s_arid,
    input  logic [7:0]  s_arlen,
    input  logic [2:0]  s_arsize,
    input  logic [1:0]  s_arburst,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rlast,
    output logic [3:0]  s_rid
);
    localparam int AW = $clog2(DEPTH_WORDS);
    slave_state_t state, next_state;
    logic [4:0] cnt, load_cnt;
    logic [31:0] addr, wdata, off;
    logic [3:0] id, wstrb;
    logic [7:0] len;
    logic [1:0] resp;
    logic [15:0] lfsr;
    logic [AW-1:0] idx;
    logic aw_got, w_got, ar_hs, aw_hs, w_hs, in_range, access, commit_wr;
    logic [31:0] mem [DEPTH_WORDS];
    logic unused_ok;
    lfsr16 u_lfsr (.clock(clock), .reset(reset), .seed(16'hACE1), .enable(1'b1), .state(lfsr));
    assign unused_ok = ^{s_awsize, s_awburst, s_arsize, s_arburst, s_wlast, lfsr[15:3]};
    // reads take priority: AW/W are held off in any IDLE cycle that offers AR
    assign s_arready = state == IDLE;
    assign s_awready = (state == IDLE && !s_arvalid) || (state == WR_COLLECT && !aw_got);
    assign s_wready  = (state == IDLE && !s_arvalid) || (state == WR_COLLECT && !w_got);
    assign s_rvalid  = state == RD_RESP;
    assign s_bvalid  = state == WR_RESP;
    assign ar_hs     = s_arvalid && s_arready;
    assign aw_hs     = s_awvalid && s_awready;
    assign w_hs      = s_wvalid && s_wready;
    assign load_cnt  = 5'(LAT_MIN) + (LFSR_EN != 0 ? {2'b00, lfsr[2:0]} : 5'd0);
    assign off       = addr - ADDR_BASE;
    assign in_range  = off < 32'(4 * DEPTH_WORDS);
    assign idx       = off[AW+1:2];
    assign resp      = !in_range ? RESP_DECERR : len != 0 ? RESP_SLVERR : RESP_OKAY;
    assign access    = cnt == 0 && (state == RD_DLY || state == WR_DLY);
    assign commit_wr = access && state == WR_DLY && resp == RESP_OKAY;
    always_comb begin
        next_state = state;
        case (state)
            IDLE:       next_state = ar_hs ? RD_DLY : (aw_hs && w_hs) ? WR_DLY : (aw_hs || w_hs) ? WR_COLLECT : IDLE;
            WR_COLLECT: next_state = ((aw_got || aw_hs) && (w_got || w_hs)) ? WR_DLY : WR_COLLECT;
            RD_DLY:     next_state = cnt == 0 ? RD_RESP : RD_DLY;
            WR_DLY:     next_state = cnt == 0 ? WR_RESP : WR_DLY;
            RD_RESP:    next_state = s_rready ? IDLE : RD_RESP;
            WR_RESP:    next_state = s_bready ? IDLE : WR_RESP;
            default:    next_state = IDLE;
        endcase
    end
    always_ff @(posedge clock)
        if (reset) state <= IDLE;
        else state <= next_state;
    always_ff @(posedge clock)
        if (reset) begin
            cnt     <= '0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            addr    <= '0;
            id      <= '0;
            len     <= '0;
            wdata   <= '0;
            wstrb   <= '0;
            s_rdata <= '0;
            s_rresp <= RESP_OKAY;
            s_rlast <= 1'b0;
            s_rid   <= '0;
            s_bresp <= RESP_OKAY;
            s_bid   <= '0;
        end else begin
            aw_got <= next_state == WR_COLLECT && (aw_got || aw_hs);
            w_got  <= next_state == WR_COLLECT && (w_got || w_hs);
            if (ar_hs) begin
                addr <= s_araddr;
                id   <= s_arid;
                len  <= s_arlen;
            end
            if (aw_hs) begin
                addr <= s_awaddr;
                id   <= s_awid;
                len  <= s_awlen;
            end
            if (w_hs) begin
                wdata <= s_wdata;
                wstrb <= s_wstrb;
            end
            if ((next_state == RD_DLY || next_state == WR_DLY) && next_state != state) cnt <= load_cnt;
            else if (cnt != 0) cnt <= cnt - 1'b1;
            if (access && state == RD_DLY) begin
                s_rdata <= in_range ? mem[idx] : '0;
                s_rresp <= resp;
                s_rid   <= id;
                s_rlast <= 1'b1;
            end
            if (s_rvalid && s_rready) s_rlast <= 1'b0;
            if (access && state == WR_DLY) begin
                s_bresp <= resp;
                s_bid   <= id;
            end
        end
    // a write landing on the same edge as reset is dropped with the rest of the transaction
    always_ff @(posedge clock)
        if (!reset && commit_wr)
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: randomized scoreboard bench for axi_sram_slave against a word-array memory model
module tb_axi_sram_slave;
    import axi_pkg::*;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int DEPTH = 4096;
    typedef struct packed { logic [31:0] data; logic [1:0] resp; logic [3:0] id; } rexp_t;
    typedef struct packed { logic [1:0] resp; logic [3:0] id; } bexp_t;
    logic clock = 1'b0, reset = 1'b1;
    logic awvalid = 0, wvalid = 0, arvalid = 0, arvalid2 = 0, rready = 1, bready = 1;
    logic [31:0] awaddr = 0, araddr = 0, wdata = 0;
    logic [3:0] awid = 0, arid = 0, wstrb = 0;
    logic [7:0] awlen = 0, arlen = 0;
    logic awready, wready, bvalid, arready, rvalid, rlast;
    logic [1:0] bresp, rresp;
    logic [3:0] bid, rid;
    logic [31:0] rdata;
    logic awready2, wready2, bvalid2, arready2, rvalid2, rlast2;
    logic [1:0] bresp2, rresp2;
    logic [3:0] bid2, rid2;
    logic [31:0] rdata2;
    int n_cmp = 0, n_bad = 0, hold = 0;
    bit rand_rdy = 0;
    rexp_t rq[$], rq2[$];
    bexp_t bq[$];
    logic [31:0] mem_m [int];
    always #5 clock = ~clock;
    axi_sram_slave #(.LAT_MIN(0), .LFSR_EN(0)) dut (
        .clock(clock), .reset(reset),
        .s_awvalid(awvalid), .s_awready(awready), .s_awaddr(awaddr), .s_awid(awid), .s_awlen(awlen),
        .s_awsize(SIZE_W), .s_awburst(BURST_INCR),
        .s_wvalid(wvalid), .s_wready(wready), .s_wdata(wdata), .s_wstrb(wstrb), .s_wlast(1'b1),
        .s_bvalid(bvalid), .s_bready(bready), .s_bresp(bresp), .s_bid(bid),
        .s_arvalid(arvalid), .s_arready(arready), .s_araddr(araddr), .s_arid(arid), .s_arlen(arlen),
        .s_arsize(SIZE_W), .s_arburst(BURST_INCR),
        .s_rvalid(rvalid), .s_rready(rready), .s_rdata(rdata), .s_rresp(rresp), .s_rlast(rlast), .s_rid(rid));
    axi_sram_slave #(.LAT_MIN(3), .LFSR_EN(1)) dut2 (
        .clock(clock), .reset(reset),
        .s_awvalid(1'b0), .s_awready(awready2), .s_awaddr(32'h0), .s_awid(4'h0), .s_awlen(8'h0),
        .s_awsize(SIZE_W), .s_awburst(BURST_INCR),
        .s_wvalid(1'b0), .s_wready(wready2), .s_wdata(32'h0), .s_wstrb(4'h0), .s_wlast(1'b1),
        .s_bvalid(bvalid2), .s_bready(1'b1), .s_bresp(bresp2), .s_bid(bid2),
        .s_arvalid(arvalid2), .s_arready(arready2), .s_araddr(araddr), .s_arid(arid), .s_arlen(arlen),
        .s_arsize(SIZE_W), .s_arburst(BURST_INCR),
        .s_rvalid(rvalid2), .s_rready(rready), .s_rdata(rdata2), .s_rresp(rresp2), .s_rlast(rlast2), .s_rid(rid2));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask
    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got no handshake within bound, expected one", nm);
    endtask
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bit in_rng(logic [31:0] a);
        return a >= BASE && a < BASE + 32'(4 * DEPTH);
    endfunction
    function automatic int widx(logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction
    function automatic rexp_t model_read(logic [31:0] a, logic [3:0] id, logic [7:0] len);
        rexp_t e;
        e.id = id;
        e.data = 32'h0;
        e.resp = 2'b11;
        if (in_rng(a)) begin
            e.data = mem_m.exists(widx(a)) ? mem_m[widx(a)] : 32'h0;
            e.resp = len != 0 ? 2'b10 : 2'b00;
        end
        return e;
    endfunction
    function automatic bexp_t model_write(logic [31:0] a, logic [3:0] id, logic [7:0] len, logic [31:0] d, logic [3:0] strb);
        bexp_t e;
        logic [31:0] w;
        e.id = id;
        e.resp = !in_rng(a) ? 2'b11 : len != 0 ? 2'b10 : 2'b00;
        if (e.resp == 2'b00) begin
            w = mem_m.exists(widx(a)) ? mem_m[widx(a)] : 32'h0;
            for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = d[8*b +: 8];
            mem_m[widx(a)] = w;
        end
        return e;
    endfunction

    // monitors: compare every presented response against the queue head, pop on handshake
    always @(negedge clock) if (!reset) begin
        if (rvalid) begin
            if (rq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL r_unexpected: got rvalid=1, expected no read response");
            end else begin
                check("rdata", rdata, rq[0].data);
                check("rresp", 32'(rresp), 32'(rq[0].resp));
                check("rid", 32'(rid), 32'(rq[0].id));
                check("rlast", 32'(rlast), 32'd1);
                if (rready) void'(rq.pop_front());
            end
        end
        if (bvalid) begin
            if (bq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL b_unexpected: got bvalid=1, expected no write response");
            end else begin
                check("bresp", 32'(bresp), 32'(bq[0].resp));
                check("bid", 32'(bid), 32'(bq[0].id));
                if (bready) void'(bq.pop_front());
            end
        end
        if (rvalid2) begin
            if (rq2.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL r2_unexpected: got rvalid=1, expected no read response");
            end else begin
                check("r2data", rdata2, rq2[0].data);
                check("r2resp", 32'(rresp2), 32'(rq2[0].resp));
                check("r2id", 32'(rid2), 32'(rq2[0].id));
                if (rready) void'(rq2.pop_front());
            end
        end
    end

    always @(posedge clock) begin
        #2;
        if (hold > 0) begin
            rready = 0;
            bready = 0;
            if (rvalid || bvalid) hold--;
        end else if (rand_rdy) begin
            rready = 1'($urandom_range(0, 1));
            bready = 1'($urandom_range(0, 1));
        end else begin
            rready = 1;
            bready = 1;
        end
    end

    function automatic logic rdy(int w);
        return w == 0 ? awready && wready : w == 1 ? awready : w == 2 ? wready : w == 3 ? arready : arready2;
    endfunction
    task automatic wait_rdy(input int w, input string nm);
        int k = 0;
        while (!rdy(w) && k < 100) begin tick(); k++; end
        if (!rdy(w)) timeout(nm);
    endtask
    task automatic drain_r();
        int k = 0;
        while (rq.size() != 0 && k < 300) begin tick(); k++; end
        if (rq.size() != 0) begin timeout("r_drain"); rq.delete(); end
    endtask
    task automatic drain_b();
        int k = 0;
        while (bq.size() != 0 && k < 300) begin tick(); k++; end
        if (bq.size() != 0) begin timeout("b_drain"); bq.delete(); end
    endtask

    task automatic read1(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input bit chk_lat);
        int lat;
        rq.push_back(model_read(a, id, len));
        araddr = a; arid = id; arlen = len; arvalid = 1;
        wait_rdy(3, "ar_hs");
        tick();
        arvalid = 0;
        lat = 1;
        while (!rvalid && lat < 100) begin tick(); lat++; end
        if (chk_lat) check("r_latency", 32'(lat), 32'd2);
        drain_r();
    endtask
    task automatic read2(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        int lat;
        rq2.push_back(model_read(a, id, len));
        araddr = a; arid = id; arlen = len; arvalid2 = 1;
        wait_rdy(4, "ar2_hs");
        tick();
        arvalid2 = 0;
        lat = 1;
        while (!rvalid2 && lat < 100) begin tick(); lat++; end
        n_cmp++;
        if (lat < 5 || lat > 12) begin
            n_bad++;
            $display("FAIL r2_latency: got %0d, expected 5..12", lat);
        end
        begin
            int k = 0;
            while (rq2.size() != 0 && k < 300) begin tick(); k++; end
            if (rq2.size() != 0) begin timeout("r2_drain"); rq2.delete(); end
        end
    endtask
    task automatic write1(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [31:0] d, input logic [3:0] strb, input int mode, input int gap);
        bq.push_back(model_write(a, id, len, d, strb));
        awaddr = a; awid = id; awlen = len; wdata = d; wstrb = strb;
        if (mode == 0) begin
            awvalid = 1; wvalid = 1;
            wait_rdy(0, "aww_hs");
            tick();
            awvalid = 0; wvalid = 0;
        end else if (mode == 1) begin
            awvalid = 1;
            wait_rdy(1, "aw_hs");
            tick();
            awvalid = 0;
            repeat (gap) tick();
            wvalid = 1;
            wait_rdy(2, "w_hs");
            tick();
            wvalid = 0;
        end else begin
            wvalid = 1;
            wait_rdy(2, "w_hs");
            tick();
            wvalid = 0;
            repeat (gap) tick();
            awvalid = 1;
            wait_rdy(1, "aw_hs");
            tick();
            awvalid = 0;
        end
        drain_b();
    endtask

    initial begin
        repeat (3) tick();
        reset = 0;
        #1;
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rlast", 32'(rlast), 32'd0);
        check("rst_ids", {24'd0, rid, bid}, 32'd0);
        check("rst_resps", {28'd0, rresp, bresp}, 32'd0);
        tick();
        write1(BASE, 4'h1, 8'd0, 32'h0000_0413, 4'hF, 0, 0);
        read1(BASE, 4'h0, 8'd0, 1);
        write1(BASE + 32'h10, 4'h2, 8'd0, 32'hAAAA_AAAA, 4'hF, 0, 0);
        write1(BASE + 32'h10, 4'h3, 8'd0, 32'h1122_3344, 4'b0101, 1, 2);
        read1(BASE + 32'h10, 4'h4, 8'd0, 1);
        hold = 5;
        write1(BASE + 32'h14, 4'h9, 8'd0, 32'h5566_7788, 4'hF, 2, 1);
        hold = 5;
        read1(BASE + 32'h14, 4'hA, 8'd0, 1);
        read1(32'h1000_0000, 4'hB, 8'd0, 1);
        write1(BASE, 4'hC, 8'd3, 32'hDEAD_BEEF, 4'hF, 0, 0);
        read1(BASE, 4'hD, 8'd0, 1);
        // AR and AW+W offered together: read must win, write accepted right after R completes
        rq.push_back(model_read(BASE + 32'h10, 4'h5, 8'd0));
        bq.push_back(model_write(BASE + 32'h20, 4'h6, 8'd0, 32'hCAFE_F00D, 4'hF));
        araddr = BASE + 32'h10; arid = 4'h5; arlen = 0;
        awaddr = BASE + 32'h20; awid = 4'h6; awlen = 0; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        arvalid = 1; awvalid = 1; wvalid = 1;
        #1;
        check("both_arready", 32'(arready), 32'd1);
        check("both_awready", 32'(awready), 32'd0);
        check("both_wready", 32'(wready), 32'd0);
        tick();
        arvalid = 0;
        drain_r();
        check("after_r_awready", 32'(awready), 32'd1);
        check("after_r_wready", 32'(wready), 32'd1);
        tick();
        awvalid = 0; wvalid = 0;
        drain_b();
        read1(BASE + 32'h20, 4'h7, 8'd0, 1);
        write1(BASE + 32'(4 * DEPTH - 4), 4'h1, 8'd0, 32'h0BAD_F00D, 4'hF, 0, 0);
        read1(BASE + 32'(4 * DEPTH - 4), 4'h2, 8'd0, 1);
        read1(BASE + 32'(4 * DEPTH), 4'h3, 8'd0, 1);
        read1(BASE - 32'd4, 4'h4, 8'd0, 1);
        write1(BASE + 32'(4 * DEPTH), 4'h5, 8'd0, 32'h1234_5678, 4'hF, 0, 0);
        read1(BASE + 32'h13, 4'h6, 8'd0, 1);
        read1(BASE + 32'h14, 4'h8, 8'd2, 1);
        for (int i = 0; i < 16; i++) write1(BASE + 32'(4 * i), 4'($urandom), 8'd0, $urandom, 4'hF, $urandom_range(0, 2), $urandom_range(0, 3));
        rand_rdy = 1;
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [7:0] len;
            int r = $urandom_range(0, 15);
            a = r == 0 ? 32'h1000_0000 + ($urandom & 32'hFFFC) : BASE + 32'($urandom_range(0, 15) << 2) + (r == 1 ? 32'($urandom_range(1, 3)) : 32'd0);
            len = $urandom_range(0, 7) == 0 ? 8'($urandom_range(1, 255)) : 8'd0;
            if ($urandom_range(0, 1) == 1) read1(a, 4'($urandom), len, 0);
            else write1(a, 4'($urandom), len, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
        end
        for (int i = 0; i < 16; i++) read1(BASE + 32'(4 * i), 4'($urandom), 8'd0, 0);
        rand_rdy = 0;
        repeat (2) tick();
        for (int i = 0; i < 10; i++) read2(32'h1000_0000 + 32'(4 * i), 4'($urandom), 8'd0);
        // reset while dut2 is counting down its delay
        araddr = 32'h1000_0000; arid = 4'h3; arlen = 0; arvalid2 = 1;
        wait_rdy(4, "ar2_rst_hs");
        tick();
        arvalid2 = 0;
        tick();
        reset = 1;
        tick();
        reset = 0;
        #1;
        check("rst_mid_arready", 32'(arready2), 32'd1);
        begin
            int seen = 0;
            repeat (20) begin tick(); if (rvalid2) seen++; end
            check("rst_mid_rvalid_cycles", 32'(seen), 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
